// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues one-cycle-latency imem reads and buffers words in a 2-entry skid FIFO.
// Optional perf counters (StallCount_o/RedirectCount_o) are enabled by defining FETCH_PERF_EN.
module fetch_unit #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ImemReq_o,
    output logic [DATA_WIDTH-1:0] ImemAddr_o,
    input  logic [DATA_WIDTH-1:0] ImemRdata_i,
    input  logic                  StallF_i,
    input  logic                  PCSrcE_i,
    input  logic [DATA_WIDTH-1:0] PCTargetE_i,
    output logic                  ValidF_o,
    output logic [DATA_WIDTH-1:0] PCF_o,
    output logic [DATA_WIDTH-1:0] InstrF_o,
    output logic [DATA_WIDTH-1:0] PCPlus4F_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]           StallCount_o,
    output logic [31:0]           RedirectCount_o
`endif
);

    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [DATA_WIDTH-1:0] req_pc_q, req_pc_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            count_q, count_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic [DATA_WIDTH-1:0] fifo_pc_q [2];
    logic [DATA_WIDTH-1:0] fifo_instr_q [2];

    logic       pop, push, req;
    logic [2:0] occupancy;
    logic       unused_tgt_lsbs;

    assign unused_tgt_lsbs = ^PCTargetE_i[1:0];

    assign ValidF_o   = (count_q != 2'd0);
    assign pop        = ValidF_o & ~StallF_i & ~PCSrcE_i;
    assign push       = inflight_q & ~PCSrcE_i;
    // Occupancy after this cycle's pop; a new request needs room for its response.
    assign occupancy  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign req        = ~rst & ~PCSrcE_i & (occupancy <= 3'd1);
    assign ImemReq_o  = req;
    assign ImemAddr_o = fetch_pc_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = 1'b0;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        if (PCSrcE_i) begin
            fetch_pc_d = {PCTargetE_i[DATA_WIDTH-1:2], 2'b00};
            count_d    = 2'd0;
            rd_ptr_d   = 1'b0;
            wr_ptr_d   = 1'b0;
        end else begin
            count_d  = count_q + {1'b0, push} - {1'b0, pop};
            rd_ptr_d = rd_ptr_q ^ pop;
            wr_ptr_d = wr_ptr_q ^ push;
            if (req) begin
                fetch_pc_d = fetch_pc_q + DATA_WIDTH'(4);
                req_pc_d   = fetch_pc_q;
                inflight_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_pc_q[i]    <= '0;
                fifo_instr_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            if (push) begin
                fifo_pc_q[wr_ptr_q]    <= req_pc_q;
                fifo_instr_q[wr_ptr_q] <= ImemRdata_i;
            end
        end
    end

    always_comb begin
        PCF_o      = '0;
        InstrF_o   = '0;
        PCPlus4F_o = '0;
        if (ValidF_o) begin
            PCF_o      = fifo_pc_q[rd_ptr_q];
            InstrF_o   = fifo_instr_q[rd_ptr_q];
            PCPlus4F_o = fifo_pc_q[rd_ptr_q] + DATA_WIDTH'(4);
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt_q, redirect_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            if (ValidF_o & StallF_i) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (PCSrcE_i) begin
                redirect_cnt_q <= redirect_cnt_q + 32'd1;
            end
        end
    end

    assign StallCount_o    = stall_cnt_q;
    assign RedirectCount_o = redirect_cnt_q;
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Fetch-stage producer for the Fetch→Decode pipeline register. It owns the program counter, issues word reads to a synchronous instruction memory with one-cycle latency, and buffers returned words in a 2-entry skid FIFO. It presents PCF/InstrF/PCPlus4F with a valid flag to the F/D register and honours downstream stall and execute-stage redirects.

## Interface
- DATA_WIDTH, 32, width of PC, instruction and address paths
- RESET_PC, 0, first fetch address after reset (word-aligned)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- ImemReq  out  1  read request this cycle
- ImemAddr  out  DATA_WIDTH  word-aligned read address, valid when ImemReq=1
- ImemRdata  in  DATA_WIDTH  read data, valid the cycle after a request
- StallF  in  1  F/D register cannot accept this cycle
- PCSrcE  in  1  redirect from execute (taken branch/jump)
- PCTargetE  in  DATA_WIDTH  redirect target
- ValidF  out  1  PCF/InstrF/PCPlus4F hold a fetched instruction
- PCF  out  DATA_WIDTH  PC of head instruction
- InstrF  out  DATA_WIDTH  head instruction word
- PCPlus4F  out  DATA_WIDTH  PCF + 4

## Operation
- State: FetchPC (next address to request), Inflight flag, 2-entry FIFO of {pc, instr}, count 0..2.
- Pop = ValidF & ~StallF & ~PCSrcE. ValidF = (count != 0).
- Request condition: ~rst & ~PCSrcE & (count + Inflight − Pop ≤ 1). ImemAddr = FetchPC. On request: FetchPC ← FetchPC + 4, Inflight ← 1, else Inflight ← 0.
- Response: when Inflight=1 and no redirect this cycle, push {address of that request, ImemRdata}. Push and pop in same cycle legal at any count; the request condition guarantees no push to a full FIFO.
- Redirect (PCSrcE=1): FIFO flushed (count ← 0), in-flight response discarded, Inflight ← 0, FetchPC ← {PCTargetE[DATA_WIDTH-1:2], 2'b00}, no request this cycle. Redirect overrides StallF and any pop.
- Outputs when ValidF=0: PCF, InstrF, PCPlus4F driven 0. PCPlus4F = PCF + 4 mod 2^DATA_WIDTH.
- FetchPC wraps: 0xFFFFFFFC + 4 = 0x00000000; no error.
- Reset: FetchPC=RESET_PC, count=0, Inflight=0 → ValidF=0, PCF=InstrF=PCPlus4F=0, ImemReq=0. Reset mid-stream drops buffered and in-flight data.

## Timing
- Cycle 0 after reset release: request RESET_PC. Cycle 1: word pushed. Cycle 2: ValidF=1, PCF=RESET_PC. Fetch-to-valid latency 2 cycles.
- Steady state with StallF=0: one request, one push, one pop per cycle; consecutive PCs each cycle.
- StallF asserted: head held stable; at most 2 entries plus no further requests once count+Inflight=2; release resumes with zero bubbles.
- Redirect in cycle N: request to target in N+1, ValidF=0 in N+1 and N+2, target instruction valid in N+3.
- ImemReq/ImemAddr combinational from registered state, PCSrcE, StallF.

## Configuration
- FETCH_PERF_EN defined: two extra outputs, StallCount and RedirectCount (32-bit each), reset to 0, incrementing on cycles with ValidF&StallF and with PCSrcE respectively; wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Reset release, RESET_PC=0x100, StallF=0, memory word = address → ValidF high from cycle 2, PCF 0x100, 0x104, 0x108… one per cycle, InstrF equals PCF, PCPlus4F = PCF+4.
- Stall 5 cycles while streaming → head PCF frozen, ImemReq drops after count+Inflight=2, after release sequence continues with no missing/duplicate PC.
- PCSrcE=1, PCTargetE=0x2003 while FIFO full and request in flight → ValidF=0 next two cycles, ImemAddr=0x2000 next cycle, then PCF 0x2000, 0x2004.
- Redirect coincident with StallF=1 → redirect taken, stall ignored for flush; same behaviour as previous case.
- RESET_PC=0xFFFFFFF8 → PCF 0xFFFFFFF8, 0xFFFFFFFC (PCPlus4F 0), 0x00000000.
- rst asserted mid-stall with 2 buffered entries → outputs immediately 0, ValidF=0; after release restart at RESET_PC; with FETCH_PERF_EN counters read 0.
